// File: rtl/iter_arith_unit.sv
// iter_arith_unit: handshaked signed add/sub/compare unit with an optional iterative shift-add multiplier.
// Build option ITER_ARITH_MUL_EN: when defined, opcode 10 runs a multi-cycle multiply (o_busy high for M cycles);
// when undefined, opcode 10 completes in one cycle as an error and o_busy is tied low.
// Ports: i_clk clock; i_reset async active-low reset; i_start/i_op/i_arg_A/i_arg_B request (taken when not busy);
//        o_busy multiply in flight; o_done one-cycle completion pulse; o_result/o_status held until next o_done.
//        o_status = {ERR, EVEN, NEG, OVF}.
module iter_arith_unit #(
    parameter int M = 8,
    parameter int N = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [N-1:0] i_op,
    input  logic [M-1:0] i_arg_A,
    input  logic [M-1:0] i_arg_B,
    output logic         o_busy,
    output logic         o_done,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);
    logic         accept, fin, fin_ok, sc_ok;
    logic [M-1:0] fin_res, sc_res, cmp_res;
    logic [M:0]   sum, diff;
    assign accept  = i_start && !o_busy;
    // One extra sign bit makes overflow visible as a mismatch of the top two bits.
    assign sum     = {i_arg_A[M-1], i_arg_A} + {i_arg_B[M-1], i_arg_B};
    assign diff    = {i_arg_A[M-1], i_arg_A} - {i_arg_B[M-1], i_arg_B};
    assign cmp_res = {{(M-1){1'b0}}, $signed(i_arg_A) < $signed(i_arg_B)};
    // Single-cycle path; opcode 10 is never ok here so it reports an error when no multiplier is built.
    always_comb begin
        sc_res = i_op == 2'b00 ? sum[M-1:0] : i_op == 2'b01 ? diff[M-1:0] : cmp_res;
        sc_ok  = i_op == 2'b00 ? sum[M] == sum[M-1] : i_op == 2'b01 ? diff[M] == diff[M-1] : i_op == 2'b11;
    end
`ifdef ITER_ARITH_MUL_EN
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    typedef enum logic {IDLE, MUL} state_t;
    state_t          state, state_nx;
    logic [M-1:0]    a_abs, b_abs;
    logic [2*M-1:0]  acc, acc_nx, prod;
    logic [CW-1:0]   cnt;
    logic            neg, last, mul_ok;
    assign last   = state == MUL && cnt == CW'(M - 1);
    assign o_busy = state == MUL;
    always_comb begin
        acc_nx   = acc + (b_abs[cnt] ? ({{M{1'b0}}, a_abs} << cnt) : '0);
        prod     = neg ? -acc_nx : acc_nx;
        // Fits in M signed bits when the top M+1 bits are all sign copies.
        mul_ok   = &prod[2*M-1:M-1] || ~|prod[2*M-1:M-1];
        state_nx = state == IDLE ? ((accept && i_op == 2'b10) ? MUL : IDLE) : (last ? IDLE : MUL);
    end
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            a_abs <= '0;
            b_abs <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
        end else if (state == IDLE) begin
            if (accept && i_op == 2'b10) begin
                a_abs <= i_arg_A[M-1] ? -i_arg_A : i_arg_A;
                b_abs <= i_arg_B[M-1] ? -i_arg_B : i_arg_B;
                neg   <= i_arg_A[M-1] ^ i_arg_B[M-1];
                acc   <= '0;
                cnt   <= '0;
            end
        end else begin
            acc <= acc_nx;
            cnt <= last ? '0 : cnt + 1'b1;
        end
    assign fin     = (accept && i_op != 2'b10) || last;
    assign fin_ok  = last ? mul_ok : sc_ok;
    assign fin_res = last ? prod[M-1:0] : sc_res;
`else
    assign o_busy  = 1'b0;
    assign fin     = accept;
    assign fin_ok  = sc_ok;
    assign fin_res = sc_res;
`endif
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            o_done   <= 1'b0;
            o_result <= '0;
            o_status <= 4'b0000;
        end else begin
            o_done <= fin;
            if (fin) begin
                o_result <= fin_ok ? fin_res : '0;
                o_status <= fin_ok ? {1'b0, ~^fin_res, fin_res[M-1], 1'b0} : 4'b1001;
            end
        end
endmodule
